// File: rtl/dec_scan_nx.sv
`default_nettype none
// ============================================================================
//  Module      : dec_scan_nx
//  Description : Registered N-to-2^N one-hot decoder with enable, plus an
//                auto-scan mode that sweeps the active line with a
//                programmable dwell time (keypad strobing, LED digit mux).
//                Optional macro DEC_SCAN_BREAK_BEFORE_MAKE_EN inserts one
//                blank cycle before each new line in scan mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module dec_scan_nx #(
    parameter int N     = 2,
    parameter int DWELL = 4,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        I,
    input  logic                Enable,
    input  logic                Mode,
    input  logic                Load,
    output logic [(1<<N)-1:0]   D,
    output logic [N-1:0]        Idx,
    output logic                Valid,
    output logic                Wrap
);

    localparam int             c_lines      = 1 << N;
    localparam logic [DW-1:0]  c_dwell_last = DW'(DWELL - 1);
    localparam logic [N-1:0]   c_idx_last   = {N{1'b1}};

`ifdef DEC_SCAN_BREAK_BEFORE_MAKE_EN
    localparam bit             c_bbm        = 1'b1;
`else
    localparam bit             c_bbm        = 1'b0;
`endif

    if (N < 1 || DWELL < 1 || DW < 1 || DW < $clog2(DWELL)) begin : g_param_check
        $error("dec_scan_nx: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_idx;
    logic [DW-1:0]        r_cnt;
    logic [c_lines-1:0]   r_d;
    logic                 r_valid;
    logic                 r_wrap;
    logic                 r_pend;
    logic                 r_blank;

    state_t               w_nstate;
    logic [N-1:0]         w_idx_n;
    logic [DW-1:0]        w_cnt_n;
    logic                 w_pend_n;
    logic                 w_blank_n;
    logic                 w_show;
    logic                 w_wrap_n;
    logic                 w_advance;
    logic                 w_expire;
    logic [c_lines-1:0]   w_onehot;

    always_comb begin
        w_nstate = ST_IDLE;
        if (Enable) begin
            w_nstate = Mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // A displayed scan cycle is counted on the edge that ends it, even when
    // that edge disables the block, so a paused line resumes with the
    // remaining dwell only. Blank cycles are never counted.
    assign w_expire  = (r_cnt == c_dwell_last);
    assign w_advance = (r_state == ST_SCAN) && !r_blank && !Load &&
                       (w_nstate != ST_DIRECT);

    always_comb begin
        w_idx_n   = r_idx;
        w_cnt_n   = r_cnt;
        w_pend_n  = r_pend;
        w_blank_n = 1'b0;
        w_show    = 1'b0;
        w_wrap_n  = 1'b0;

        if (w_advance) begin
            if (w_expire) begin
                w_cnt_n = '0;
                w_idx_n = r_idx + N'(1);
                if (r_idx == c_idx_last) begin
                    w_pend_n = 1'b1;
                end
            end else begin
                w_cnt_n = r_cnt + DW'(1);
            end
        end

        case (w_nstate)
            ST_IDLE: begin
                if (Load) begin
                    w_idx_n  = I;
                    w_pend_n = 1'b0;
                end
            end
            ST_DIRECT: begin
                w_cnt_n  = '0;
                w_pend_n = 1'b0;
                w_show   = 1'b1;
                if (Load) begin
                    w_idx_n = I;
                end
            end
            ST_SCAN: begin
                w_show = 1'b1;
                if (Load) begin
                    w_idx_n  = I;
                    w_cnt_n  = '0;
                    w_pend_n = 1'b0;
                    if (c_bbm && (r_state == ST_SCAN)) begin
                        w_show    = 1'b0;
                        w_blank_n = 1'b1;
                    end
                end else if (c_bbm && w_advance && w_expire) begin
                    w_show    = 1'b0;
                    w_blank_n = 1'b1;
                end
            end
            default: begin
                w_show = 1'b0;
            end
        endcase

        // Wrap is held pending until line 0 is actually shown, which covers
        // both the blank cycle and a disable landing on the wrapping step.
        if (w_show && w_pend_n) begin
            w_wrap_n = 1'b1;
            w_pend_n = 1'b0;
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < c_lines; k++) begin
            w_onehot[k] = (w_idx_n == N'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_pend  <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_idx_n;
            r_cnt   <= w_cnt_n;
            r_d     <= w_show ? w_onehot : '0;
            r_valid <= w_show;
            r_wrap  <= w_wrap_n;
            r_pend  <= w_pend_n;
            r_blank <= w_blank_n;
        end
    end

    assign D     = r_d;
    assign Idx   = r_idx;
    assign Valid = r_valid;
    assign Wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dec_scan_nx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_scan_nx
//  Description : Scoreboard bench for dec_scan_nx (N=2, DWELL=3); expected
//                outputs are queued with each stimulus cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dec_scan_nx;

    localparam int N     = 2;
    localparam int DWELL = 3;
    localparam int DW    = 8;

`ifdef DEC_SCAN_BREAK_BEFORE_MAKE_EN
    localparam bit BBM = 1'b1;
`else
    localparam bit BBM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] I = '0;
    logic       Enable = 1'b0;
    logic       Mode = 1'b0;
    logic       Load = 1'b0;
    logic [3:0] D;
    logic [1:0] Idx;
    logic       Valid;
    logic       Wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus {rst,Enable,Mode,Load,I}, expected {D,Idx,Valid,Wrap}
    logic [5:0] stim_q[$];
    logic [7:0] exp_q[$];

    dec_scan_nx #(.N(N), .DWELL(DWELL), .DW(DW)) dut (
        .clk(clk), .rst(rst), .I(I), .Enable(Enable), .Mode(Mode),
        .Load(Load), .D(D), .Idx(Idx), .Valid(Valid), .Wrap(Wrap)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic m, input logic l,
                       input logic [1:0] i, input logic [3:0] d, input logic [1:0] x,
                       input logic v, input logic w);
        stim_q.push_back({r, e, m, l, i});
        exp_q.push_back({d, x, v, w});
    endtask

    task automatic test_reset();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        add(1, 1, 1, 1, 2'd3, 4'b0000, 2'd0, 0, 0);
        add(1, 1, 0, 1, 2'd2, 4'b0000, 2'd0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL reset[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_direct();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        add(0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 0, 0, 2'd3, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 0, 1, 2'd0, 4'b0001, 2'd0, 1, 0);
        add(0, 1, 0, 1, 2'd3, 4'b1000, 2'd3, 1, 0);
        add(0, 1, 0, 0, 2'd1, 4'b1000, 2'd3, 1, 0);
        add(0, 1, 0, 1, 2'd2, 4'b0100, 2'd2, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL direct[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_disable();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        add(0, 0, 0, 0, 2'd0, 4'b0000, 2'd2, 0, 0);
        add(0, 0, 0, 0, 2'd0, 4'b0000, 2'd2, 0, 0);
        add(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        add(0, 0, 0, 1, 2'd1, 4'b0000, 2'd1, 0, 0);
        add(0, 1, 0, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL disable[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_scan_sweep();
        logic [5:0] s;
        logic [7:0] e;
        logic [3:0] one = 4'b0001;
        int k = 0;
        add(0, 1, 1, 1, 2'd0, 4'b0001, 2'd0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
        for (int ln = 1; ln < 4; ln++) begin
            if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'(ln), 0, 0);
            for (int c = 0; c < DWELL; c++) begin
                add(0, 1, 1, 0, 2'd0, one << ln, 2'(ln), 1, 0);
            end
        end
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 1);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL scan_sweep[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_load_collision();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        if (BBM) begin
            add(0, 1, 1, 1, 2'd1, 4'b0000, 2'd1, 0, 0);
            add(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        end else begin
            add(0, 1, 1, 1, 2'd1, 4'b0010, 2'd1, 1, 0);
        end
        add(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        // dwell counter is at its last value here: Load must win
        if (BBM) begin
            add(0, 1, 1, 1, 2'd3, 4'b0000, 2'd3, 0, 0);
            add(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
        end else begin
            add(0, 1, 1, 1, 2'd3, 4'b1000, 2'd3, 1, 0);
        end
        add(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 1);
        add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL load_collision[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_pause_resume();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        if (BBM) begin
            add(0, 1, 1, 1, 2'd2, 4'b0000, 2'd2, 0, 0);
            add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        end else begin
            add(0, 1, 1, 1, 2'd2, 4'b0100, 2'd2, 1, 0);
        end
        for (int c = 0; c < 5; c++) add(0, 0, 1, 0, 2'd0, 4'b0000, 2'd2, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd3, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
        add(1, 1, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        for (int c = 0; c < DWELL; c++) add(0, 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 0);
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd1, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL pause_resume[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    task automatic test_mode_switch();
        logic [5:0] s;
        logic [7:0] e;
        int k = 0;
        add(0, 1, 0, 1, 2'd1, 4'b0010, 2'd1, 1, 0);
        add(0, 1, 0, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        for (int c = 0; c < DWELL; c++) add(0, 1, 1, 0, 2'd0, 4'b0010, 2'd1, 1, 0);
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd2, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        add(0, 1, 0, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        for (int c = 0; c < DWELL; c++) add(0, 1, 1, 0, 2'd0, 4'b0100, 2'd2, 1, 0);
        if (BBM) add(0, 1, 1, 0, 2'd0, 4'b0000, 2'd3, 0, 0);
        add(0, 1, 1, 0, 2'd0, 4'b1000, 2'd3, 1, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {rst, Enable, Mode, Load, I} = s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({D, Idx, Valid, Wrap} !== e) begin
                n_fail++;
                $display("FAIL mode_switch[%0d]: D=%b Idx=%0d Valid=%b Wrap=%b, expected D=%b Idx=%0d Valid=%b Wrap=%b",
                         k, D, Idx, Valid, Wrap, e[7:4], e[3:2], e[1], e[0]);
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_disable();
        test_scan_sweep();
        test_load_collision();
        test_pause_resume();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
